// File: rtl/data_mem_responder.sv
// Load/store responder for the core data-memory port: 512-byte RAM, multi-cycle loads, single-cycle stores.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | accepting requests; stores complete here
// WAIT  | load in flight, latency counter running down
// RESP  | rd_data/rd_valid presented for one cycle
module data_mem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              misalign
);
    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, next_state;
    logic [3:0]        count;
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] lat_word;
    logic [1:0]        lat_lo;
    logic [2:0]        lat_f3;

    logic              do_store, do_load;
    logic [3:0]        be;
    logic [DATA_W-1:0] wlanes;
    logic [DATA_W-1:0] src_word, shifted_b, shifted_h, load_result;
    logic [1:0]        src_lo;
    logic [2:0]        src_f3;
    logic              store_mis, load_mis, resp_mis;

    assign do_store = (state == IDLE) && MemWrite && !reset;
    assign do_load  = (state == IDLE) && MemRead && !MemWrite;

    // With READ_LAT=1 the response is captured on the acceptance edge, before the latches load.
    assign src_word = (state == IDLE) ? mem[addr[ADDR_W-1:2]] : lat_word;
    assign src_lo   = (state == IDLE) ? addr[1:0] : lat_lo;
    assign src_f3   = (state == IDLE) ? Funct3 : lat_f3;

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic is_mis(input logic [1:0] lo, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    assign store_mis = is_mis(addr[1:0], Funct3);
    assign load_mis  = is_mis(src_lo, src_f3);
    assign resp_mis  = is_mis(lat_lo, lat_f3);
`else
    assign store_mis = 1'b0;
    assign load_mis  = 1'b0;
    assign resp_mis  = 1'b0;
`endif

    always_comb begin
        be     = 4'b0000;
        wlanes = wr_data;
        case (Funct3[1:0])
            2'b00: begin
                be[addr[1:0]] = 1'b1;
                wlanes        = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wr_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
        if (store_mis) be = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr[ADDR_W-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign shifted_b = src_word >> {src_lo, 3'b000};
    assign shifted_h = src_word >> {src_lo[1], 4'b0000};

    always_comb begin
        case (src_f3)
            3'b000:  load_result = {{24{shifted_b[7]}}, shifted_b[7:0]};
            3'b100:  load_result = {24'd0, shifted_b[7:0]};
            3'b001:  load_result = {{16{shifted_h[15]}}, shifted_h[15:0]};
            3'b101:  load_result = {16'd0, shifted_h[15:0]};
            default: load_result = src_word;
        endcase
        if (load_mis) load_result = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            rd_data  <= '0;
            lat_word <= '0;
            lat_lo   <= 2'd0;
            lat_f3   <= 3'd0;
        end else begin
            state <= next_state;
            if (do_load) begin
                lat_word <= mem[addr[ADDR_W-1:2]];
                lat_lo   <= addr[1:0];
                lat_f3   <= Funct3;
                count    <= LAT_INIT;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (next_state == RESP && state != RESP) rd_data <= load_result;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (do_load) next_state = (READ_LAT == 1) ? RESP : WAIT;
            WAIT: if (count <= 4'd1) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_valid = (state == RESP);
        stall    = (state != IDLE) || do_load;
        misalign = (do_store && store_mis) || ((state == RESP) && resp_mis);
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized loads/stores
// against a byte-array memory model. Build with DMEM_ALIGN_CHECK_EN to cover alignment checking.
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite;
    logic [8:0]  addr;
    logic [2:0]  Funct3;
    logic [31:0] wr_data, rd_data;
    logic        rd_valid, stall, misalign;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [512];

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .Funct3(Funct3), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit mis_model(input logic [8:0] a, input logic [2:0] f);
`ifdef DMEM_ALIGN_CHECK_EN
        return (int'(a) % size_of(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [8:0] a, input logic [2:0] f);
        return (int'(a) / size_of(f)) * size_of(f);
    endfunction

    task automatic model_store(input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
        if (!mis_model(a, f))
            for (int i = 0; i < size_of(f); i++) model[base_of(a, f) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
        logic [31:0] v;
        v = 32'd0;
        if (mis_model(a, f)) return 32'd0;
        for (int i = 0; i < size_of(f); i++) v = v | ({24'd0, model[base_of(a, f) + i]} << (8 * i));
        if (f == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_store(input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
        bit exp_mis;
        exp_mis = mis_model(a, f);
        @(negedge clk);
        MemWrite = 1'b1; MemRead = 1'($urandom % 2);
        addr = a; Funct3 = f; wr_data = d;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_idle a=%h: stall=%b rd_valid=%b, required 0/0", a, stall, rd_valid);
        end
        checks++;
        if (misalign !== exp_mis) begin
            errors++;
            $display("FAIL store_misalign a=%h f=%0d: got %b, required %b", a, f, misalign, exp_mis);
        end
        model_store(a, f, d);
    endtask

    task automatic do_load(input logic [8:0] a, input logic [2:0] f, input logic [31:0] exp,
                           input bit exp_mis, input bit chk_data);
        int n;
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; addr = a; Funct3 = f;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_accept_stall a=%h: got %b, required 1", a, stall);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // strobes while busy must be ignored
            MemRead = 1'($urandom % 2); MemWrite = 1'($urandom % 2);
            addr = 9'($urandom); Funct3 = 3'($urandom); wr_data = $urandom;
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL load_busy_stall cycle %0d: got %b, required 1", n, stall);
            end
        end while (rd_valid !== 1'b1 && n < 20);
        checks++;
        if (rd_valid !== 1'b1 || n != LAT) begin
            errors++;
            $display("FAIL load_latency a=%h: rd_valid=%b after %0d cycles, required 1 after %0d", a, rd_valid, n, LAT);
        end
        if (chk_data) begin
            checks++;
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL load_data a=%h f=%0d: got %h, required %h", a, f, rd_data, exp);
            end
        end
        checks++;
        if (misalign !== exp_mis) begin
            errors++;
            $display("FAIL load_misalign a=%h: got %b, required %b", a, misalign, exp_mis);
        end
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL load_after a=%h: rd_valid=%b stall=%b misalign=%b, required 0/0/0", a, rd_valid, stall, misalign);
        end
        if (chk_data) begin
            checks++;
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL load_hold a=%h: got %h, required %h", a, rd_data, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        addr = '0; Funct3 = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data !== 32'd0 || rd_valid !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_data=%h rd_valid=%b stall=%b misalign=%b, required all 0", rd_data, rd_valid, stall, misalign);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data !== 32'd0 || rd_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: rd_data=%h rd_valid=%b stall=%b, required all 0", rd_data, rd_valid, stall);
        end
        do_load(9'h000, 3'd2, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_word_byte();
        do_store(9'h010, 3'd2, 32'hDEADBEEF);
        do_load(9'h010, 3'd2, 32'hDEADBEEF, 1'b0, 1'b1);
        do_load(9'h013, 3'd0, 32'hFFFFFFDE, 1'b0, 1'b1);
        do_load(9'h013, 3'd4, 32'h000000DE, 1'b0, 1'b1);
    endtask

    task automatic test_half();
        do_store(9'h020, 3'd2, 32'h11223344);
        do_store(9'h022, 3'd1, 32'hABCD8001);
        do_load(9'h020, 3'd2, 32'h80013344, 1'b0, 1'b1);
        do_load(9'h022, 3'd1, 32'hFFFF8001, 1'b0, 1'b1);
        do_load(9'h022, 3'd5, 32'h00008001, 1'b0, 1'b1);
        do_load(9'h021, 3'd4, 32'h00000033, 1'b0, 1'b1);
    endtask

    task automatic test_read_write_both();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b1; addr = 9'h040; Funct3 = 3'd2; wr_data = 32'h5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL both_stall: got %b, required 0", stall);
        end
        model_store(9'h040, 3'd2, 32'h5);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rd_valid !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL both_no_read cycle %0d: rd_valid=%b stall=%b, required 0/0", i, rd_valid, stall);
            end
            @(negedge clk);
        end
        do_load(9'h040, 3'd2, 32'h00000005, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h010; Funct3 = 3'd2;
        @(negedge clk);
        MemRead = 1'b0; reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall: got %b, required 1", stall);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_abandon: stall=%b rd_valid=%b rd_data=%h, required 0/0/0", stall, rd_valid, rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_valid cycle %0d: got %b, required 0", i, rd_valid);
            end
        end
        do_load(9'h010, 3'd2, 32'hDEADBEEF, 1'b0, 1'b1);
    endtask

    task automatic test_align();
`ifdef DMEM_ALIGN_CHECK_EN
        do_store(9'h041, 3'd2, 32'hFFFFFFFF);
        do_load(9'h040, 3'd2, 32'h00000005, 1'b0, 1'b1);
        do_load(9'h043, 3'd1, 32'h00000000, 1'b1, 1'b1);
        do_load(9'h042, 3'd5, 32'h00000000, 1'b0, 1'b1);
`else
        do_load(9'h043, 3'd2, 32'h00000005, 1'b0, 1'b1);
        do_load(9'h043, 3'd1, 32'h00000000, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_random();
        logic [8:0] a;
        logic [2:0] f;
        for (int w = 0; w < 64; w++) do_store(9'(256 + 4 * w), 3'd2, $urandom);
        for (int k = 0; k < 300; k++) begin
            a = 9'(256 + ($urandom % 256));
            f = 3'($urandom);
            if ($urandom % 2) do_store(a, f, $urandom);
            else do_load(a, f, model_load(a, f), mis_model(a, f), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half();
        test_read_write_both();
        test_reset_in_wait();
        test_align();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
